mc_ctrl: RTL and testbench

- Multi-cycle control unit that sits directly upstream of the CPU datapath.
- Drives every datapath control input: regDst, jump, branch, memRead, memToReg, aluOp, memWrite, aluSrc, regWrite and extType.
- Adds pcWrite and irWrite strobes, so the datapath PC and instruction register advance only on commit.
- Adds a memReady wait-state handshake for data memory, and counts retired instructions.

---
 rtl/mc_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control unit driving the CPU datapath control inputs.
// Sequences FETCH/DECODE/EXE/MEM/WB, strobes pcWrite/irWrite on commit,
// waits on memReady in MEM, and counts retired instructions.
// Optional feature macro: ILLEGAL_TRAP_EN (trap unrecognised instructions into HALT).
// Outputs are decoded from registered state/opcode only (plus memReady for
// the sw commit), so an asynchronous reset clears the strobes immediately.
module mc_ctrl #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instruction,
   input  logic             zero,
   input  logic             memReady,
   output logic [1:0]       regDst,
   output logic [1:0]       jump,
   output logic [1:0]       branch,
   output logic             memRead,
   output logic [1:0]       memToReg,
   output logic [2:0]       aluOp,
   output logic             memWrite,
   output logic             aluSrc,
   output logic             regWrite,
   output logic [1:0]       extType,
   output logic             pcWrite,
   output logic             irWrite,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] instrCount
`ifdef ILLEGAL_TRAP_EN
   ,
   output logic             illegal
`endif
);

   localparam int unsigned OP_W    = 6;
   localparam int unsigned FUNCT_W = 6;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXE    = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } stateT;

   typedef enum logic [3:0] {
      C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILL
   } instrClassT;

   stateT              curState;
   stateT              nextState;
   logic [OP_W-1:0]    opQ;
   logic [FUNCT_W-1:0] functQ;
   instrClassT         cls;

   logic [1:0] selRegDst;
   logic [1:0] selJump;
   logic [1:0] selBranch;
   logic [1:0] selMemToReg;
   logic [2:0] selAluOp;
   logic       selAluSrc;
   logic [1:0] selExtType;

   // The datapath uses the remaining instruction fields and the zero flag itself.
   logic unusedInputs;
   assign unusedInputs = ^{instruction[25:6], zero};

   assign state = curState;

`ifdef ILLEGAL_TRAP_EN
   assign illegal = (curState == S_HALT);
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) curState <= S_FETCH;
      else      curState <= nextState;
   end

   // Latch opcode/funct while fetching so decode is stable for the instruction
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         opQ    <= '0;
         functQ <= '0;
      end else if (curState == S_FETCH) begin
         opQ    <= instruction[31:26];
         functQ <= instruction[5:0];
      end
   end

   // Retired-instruction counter, advances on every commit cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         instrCount <= '0;
      else if (pcWrite) instrCount <= instrCount + CNT_W'(1);
   end

   // Classify the latched instruction
   always_comb begin
      cls = C_ILL;
      case (opQ)
         6'b000000: begin
            case (functQ)
               6'b100001: cls = C_ADDU;
               6'b100011: cls = C_SUBU;
               6'b001000: cls = C_JR;
               default:   cls = C_ILL;
            endcase
         end
         6'b001101: cls = C_ORI;
         6'b001111: cls = C_LUI;
         6'b100011: cls = C_LW;
         6'b101011: cls = C_SW;
         6'b000100: cls = C_BEQ;
         6'b000010: cls = C_J;
         6'b000011: cls = C_JAL;
         default:   cls = C_ILL;
      endcase
   end

   // Per-instruction datapath mux selects
   always_comb begin
      selRegDst   = 2'b00;
      selJump     = 2'b00;
      selBranch   = 2'b00;
      selMemToReg = 2'b00;
      selAluOp    = 3'b000;
      selAluSrc   = 1'b0;
      selExtType  = 2'b00;
      case (cls)
         C_ADDU: begin selRegDst = 2'b01; selMemToReg = 2'b01; selAluOp = 3'b000; end
         C_SUBU: begin selRegDst = 2'b01; selMemToReg = 2'b01; selAluOp = 3'b001; end
         C_ORI:  begin selMemToReg = 2'b01; selAluOp = 3'b010; selAluSrc = 1'b1; selExtType = 2'b00; end
         C_LUI:  begin selMemToReg = 2'b01; selAluOp = 3'b010; selAluSrc = 1'b1; selExtType = 2'b10; end
         C_LW:   begin selAluSrc = 1'b1; selExtType = 2'b01; selMemToReg = 2'b00; end
         C_SW:   begin selAluSrc = 1'b1; selExtType = 2'b01; end
         C_BEQ:  begin selAluOp = 3'b001; selBranch = 2'b01; selExtType = 2'b01; end
         C_J:    begin selJump = 2'b01; end
         C_JAL:  begin selJump = 2'b01; selRegDst = 2'b10; selMemToReg = 2'b10; end
         C_JR:   begin selJump = 2'b10; end
         default: ;
      endcase
   end

   // Next-state and control outputs
   always_comb begin
      nextState = curState;
      regDst    = 2'b00;
      jump      = 2'b00;
      branch    = 2'b00;
      memRead   = 1'b0;
      memToReg  = 2'b00;
      aluOp     = 3'b000;
      memWrite  = 1'b0;
      aluSrc    = 1'b0;
      regWrite  = 1'b0;
      extType   = 2'b00;
      pcWrite   = 1'b0;
      irWrite   = 1'b0;

      if (curState != S_FETCH && curState != S_HALT) begin
         regDst   = selRegDst;
         jump     = selJump;
         branch   = selBranch;
         memToReg = selMemToReg;
         aluOp    = selAluOp;
         aluSrc   = selAluSrc;
         extType  = selExtType;
      end

      case (curState)
         S_FETCH: begin
            irWrite   = 1'b1;
            nextState = S_DECODE;
         end
         S_DECODE: begin
            case (cls)
               C_J: begin
                  pcWrite   = 1'b1;
                  nextState = S_FETCH;
               end
               C_JAL: nextState = S_WB;
               C_ILL: begin
`ifdef ILLEGAL_TRAP_EN
                  nextState = S_HALT;
`else
                  pcWrite   = 1'b1;
                  nextState = S_FETCH;
`endif
               end
               default: nextState = S_EXE;
            endcase
         end
         S_EXE: begin
            case (cls)
               C_BEQ, C_JR: begin
                  pcWrite   = 1'b1;
                  nextState = S_FETCH;
               end
               C_LW, C_SW: nextState = S_MEM;
               default:    nextState = S_WB;
            endcase
         end
         S_MEM: begin
            if (cls == C_LW) begin
               memRead = 1'b1;
               if (memReady) nextState = S_WB;
            end else if (cls == C_SW) begin
               memWrite = 1'b1;
               if (memReady) begin
                  pcWrite   = 1'b1;
                  nextState = S_FETCH;
               end
            end else begin
               nextState = S_FETCH;
            end
         end
         S_WB: begin
            regWrite  = 1'b1;
            pcWrite   = 1'b1;
            nextState = S_FETCH;
         end
         S_HALT:  nextState = S_HALT;
         default: nextState = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed self-checking bench for mc_ctrl.
module tb_mc_ctrl;

   localparam int unsigned CNT_W = 32;

   logic             clk;
   logic             rst;
   logic [31:0]      instruction;
   logic             zero;
   logic             memReady;
   logic [1:0]       regDst;
   logic [1:0]       jump;
   logic [1:0]       branch;
   logic             memRead;
   logic [1:0]       memToReg;
   logic [2:0]       aluOp;
   logic             memWrite;
   logic             aluSrc;
   logic             regWrite;
   logic [1:0]       extType;
   logic             pcWrite;
   logic             irWrite;
   logic [2:0]       state;
   logic [CNT_W-1:0] instrCount;
`ifdef ILLEGAL_TRAP_EN
   logic             illegal;
`endif

   int nAsserts = 0;
   int nFails   = 0;

   mc_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .instruction(instruction), .zero(zero), .memReady(memReady),
      .regDst(regDst), .jump(jump), .branch(branch), .memRead(memRead), .memToReg(memToReg),
      .aluOp(aluOp), .memWrite(memWrite), .aluSrc(aluSrc), .regWrite(regWrite),
      .extType(extType), .pcWrite(pcWrite), .irWrite(irWrite), .state(state),
      .instrCount(instrCount)
`ifdef ILLEGAL_TRAP_EN
      , .illegal(illegal)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      if (obs !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive inputs between edges and let combinational outputs settle
   task automatic setIn(input logic [31:0] instr, input logic mr, input logic z);
      instruction = instr;
      memReady    = mr;
      zero        = z;
      #1;
   endtask

   // Check the current cycle's state and strobes, then advance one clock
   task automatic cyc(input string tag, input int st, input logic pc, input logic rw, input logic mw);
      checkVal({tag, " state"},    32'(state),    32'(st));
      checkVal({tag, " irWrite"},  32'(irWrite),  (st == 0) ? 32'd1 : 32'd0);
      checkVal({tag, " pcWrite"},  32'(pcWrite),  32'(pc));
      checkVal({tag, " regWrite"}, 32'(regWrite), 32'(rw));
      checkVal({tag, " memWrite"}, 32'(memWrite), 32'(mw));
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      instruction = '0;
      memReady = 1'b0;
      zero = 1'b0;

      // Reset held for three cycles
      repeat (3) @(posedge clk);
      #1;
      checkVal("rst state",  32'(state),      32'd0);
      checkVal("rst irW",    32'(irWrite),    32'd1);
      checkVal("rst count",  32'(instrCount), 32'd0);
      checkVal("rst pcW",    32'(pcWrite),    32'd0);
      checkVal("rst regW",   32'(regWrite),   32'd0);
      checkVal("rst memW",   32'(memWrite),   32'd0);
      rst = 1'b1;

      // addu
      setIn(32'h00221821, 1'b0, 1'b0);
      cyc("addu F", 0, 0, 0, 0);
      checkVal("addu regDst",   32'(regDst),   32'h1);
      checkVal("addu memToReg", 32'(memToReg), 32'h1);
      checkVal("addu aluSrc",   32'(aluSrc),   32'h0);
      checkVal("addu aluOp",    32'(aluOp),    32'h0);
      cyc("addu D", 1, 0, 0, 0);
      cyc("addu E", 2, 0, 0, 0);
      checkVal("addu wb regDst", 32'(regDst), 32'h1);
      cyc("addu W", 4, 1, 1, 0);

      // ori
      setIn(32'h34410005, 1'b0, 1'b0);
      cyc("ori F", 0, 0, 0, 0);
      checkVal("ori regDst",  32'(regDst),  32'h0);
      checkVal("ori aluSrc",  32'(aluSrc),  32'h1);
      checkVal("ori extType", 32'(extType), 32'h0);
      checkVal("ori aluOp",   32'(aluOp),   32'h2);
      cyc("ori D", 1, 0, 0, 0);
      cyc("ori E", 2, 0, 0, 0);
      cyc("ori W", 4, 1, 1, 0);
      checkVal("count after ori", 32'(instrCount), 32'd2);

      // lw with three wait cycles
      setIn(32'h8C220004, 1'b0, 1'b0);
      cyc("lw F", 0, 0, 0, 0);
      checkVal("lw extType", 32'(extType), 32'h1);
      checkVal("lw aluSrc",  32'(aluSrc),  32'h1);
      checkVal("lw memRead D", 32'(memRead), 32'h0);
      cyc("lw D", 1, 0, 0, 0);
      cyc("lw E", 2, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         checkVal("lw memRead wait", 32'(memRead), 32'h1);
         cyc("lw M wait", 3, 0, 0, 0);
      end
      setIn(32'h8C220004, 1'b1, 1'b0);
      checkVal("lw memRead rdy", 32'(memRead), 32'h1);
      cyc("lw M rdy", 3, 0, 0, 0);
      checkVal("lw memToReg", 32'(memToReg), 32'h0);
      checkVal("lw regDst",   32'(regDst),   32'h0);
      cyc("lw W", 4, 1, 1, 0);
      checkVal("count after lw", 32'(instrCount), 32'd3);

      // sw with immediate memReady
      setIn(32'hAC220008, 1'b1, 1'b0);
      cyc("sw F", 0, 0, 0, 0);
      cyc("sw D", 1, 0, 0, 0);
      cyc("sw E", 2, 0, 0, 0);
      cyc("sw M", 3, 1, 0, 1);

      // beq, zero=1
      setIn(32'h10220003, 1'b1, 1'b1);
      cyc("beq F", 0, 0, 0, 0);
      checkVal("beq branch", 32'(branch), 32'h1);
      checkVal("beq aluOp",  32'(aluOp),  32'h1);
      cyc("beq D", 1, 0, 0, 0);
      cyc("beq E", 2, 1, 0, 0);
      checkVal("count after beq", 32'(instrCount), 32'd5);

      // j
      setIn(32'h08000010, 1'b0, 1'b0);
      cyc("j F", 0, 0, 0, 0);
      checkVal("j jump", 32'(jump), 32'h1);
      cyc("j D", 1, 1, 0, 0);

      // jal
      setIn(32'h0C000010, 1'b0, 1'b0);
      cyc("jal F", 0, 0, 0, 0);
      checkVal("jal jump", 32'(jump), 32'h1);
      cyc("jal D", 1, 0, 0, 0);
      checkVal("jal regDst",   32'(regDst),   32'h2);
      checkVal("jal memToReg", 32'(memToReg), 32'h2);
      cyc("jal W", 4, 1, 1, 0);

      // jr
      setIn(32'h03E00008, 1'b0, 1'b0);
      cyc("jr F", 0, 0, 0, 0);
      checkVal("jr jump", 32'(jump), 32'h2);
      cyc("jr D", 1, 0, 0, 0);
      cyc("jr E", 2, 1, 0, 0);
      checkVal("count after jr", 32'(instrCount), 32'd8);

      // Unrecognised opcode
      setIn(32'hFC000000, 1'b0, 1'b0);
      cyc("ill F", 0, 0, 0, 0);
`ifdef ILLEGAL_TRAP_EN
      cyc("ill D", 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         checkVal("halt illegal", 32'(illegal), 32'h1);
         cyc("halt", 5, 0, 0, 0);
      end
      checkVal("halt count", 32'(instrCount), 32'd8);
      rst = 1'b0;
      #1;
      checkVal("trap rst illegal", 32'(illegal), 32'h0);
      checkVal("trap rst state",   32'(state),   32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
`else
      checkVal("nop jump",     32'(jump),     32'h0);
      checkVal("nop regDst",   32'(regDst),   32'h0);
      checkVal("nop memToReg", 32'(memToReg), 32'h0);
      checkVal("nop aluSrc",   32'(aluSrc),   32'h0);
      cyc("ill D", 1, 1, 0, 0);
      checkVal("nop count", 32'(instrCount), 32'd9);
      checkVal("nop next state", 32'(state), 32'd0);
`endif

      // sw aborted by reset while waiting in MEM
      setIn(32'hAC220008, 1'b0, 1'b0);
      cyc("swr F", 0, 0, 0, 0);
      cyc("swr D", 1, 0, 0, 0);
      cyc("swr E", 2, 0, 0, 0);
      checkVal("swr M memWrite", 32'(memWrite), 32'h1);
      checkVal("swr M state",    32'(state),    32'd3);
      rst = 1'b0;
      #1;
      checkVal("swr rst memWrite", 32'(memWrite),   32'h0);
      checkVal("swr rst pcWrite",  32'(pcWrite),    32'h0);
      checkVal("swr rst state",    32'(state),      32'd0);
      checkVal("swr rst count",    32'(instrCount), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
